// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_pkg: shared types and constants for the writeback store path      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package wb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ST_BUSY = 2'd1,
      LD_BUSY = 2'd2
   } state_t;

   // Loads and stores alias when they touch the same 32-bit word.
   localparam int WORD_LSB = 2;

   localparam logic MEM_OP_LOAD  = 1'b0;
   localparam logic MEM_OP_STORE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sq_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sq_fifo: store queue of {addr,data} with per-entry word-address match|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sq_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [31:0]            push_addr,
   input  logic [31:0]            push_data,
   input  logic [31-WORD_LSB:0]   match_word,
   output logic [31:0]            head_addr,
   output logic [31:0]            head_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty,
   output logic                   match
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

   logic [31:0]      addr_mem [DEPTH];
   logic [31:0]      data_mem [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] hit;
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   // A push while full is dropped even if a pop frees a slot this cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
      end else begin
         if (do_push) begin
            tail        <= tail + 1'b1;
            valid[tail] <= 1'b1;
         end
         if (do_pop) begin
            head        <= head + 1'b1;
            valid[head] <= 1'b0;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         addr_mem[tail] <= push_addr;
         data_mem[tail] <= push_data;
      end
   end

   assign head_addr = addr_mem[head];
   assign head_data = data_mem[head];

   for (genvar i = 0; i < DEPTH; i++) begin : g_match
      assign hit[i] = valid[i] && (addr_mem[i][31:WORD_LSB] == match_word);
   end

   assign match = |hit;

endmodule
`default_nettype wire

// File: rtl/wb_store_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_store_ctrl: store queue plus load/store arbiter for the D-mem port|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wb_store_ctrl
   import wb_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 4
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_st_valid,
   input  logic [31:0]            i_st_addr,
   input  logic [31:0]            i_st_data,
   output logic                   o_st_stall,
   input  logic                   i_ld_req,
   input  logic [31:0]            i_ld_addr,
   output logic                   o_ld_conflict,
   output logic                   o_ld_done,
   output logic                   o_mem_req,
   output logic                   o_mem_we,
   output logic [31:0]            o_mem_addr,
   output logic [31:0]            o_mem_data,
   input  logic                   i_mem_ack,
   output logic [$clog2(DEPTH):0] o_sq_count,
   output logic                   o_sq_empty
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   state_t        state;
   logic [SW-1:0] starve;
   logic [31:0]   head_addr;
   logic [31:0]   head_data;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_match;
   logic          pop;
   logic          force_store;

   sq_fifo #(
      .DEPTH (DEPTH)
   ) u_sq_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (i_st_valid),
      .pop        (pop),
      .push_addr  (i_st_addr),
      .push_data  (i_st_data),
      .match_word (i_ld_addr[31:WORD_LSB]),
      .head_addr  (head_addr),
      .head_data  (head_data),
      .count      (o_sq_count),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .match      (fifo_match)
   );

   assign o_st_stall    = fifo_full;
   assign o_sq_empty    = fifo_empty;
   assign o_ld_conflict = i_ld_req && fifo_match;
   assign pop           = (state == ST_BUSY) && i_mem_ack;
   // Load data is valid on the memory ack itself, so done is not delayed.
   assign o_ld_done     = (state == LD_BUSY) && i_mem_ack;
   assign force_store   = fifo_full || (starve == STARVE_MAX) ||
                          o_ld_conflict || !i_ld_req;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         starve     <= '0;
         o_mem_req  <= 1'b0;
         o_mem_we   <= 1'b0;
         o_mem_addr <= '0;
         o_mem_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty && force_store) begin
                  state      <= ST_BUSY;
                  starve     <= '0;
                  o_mem_req  <= 1'b1;
                  o_mem_we   <= MEM_OP_STORE;
                  o_mem_addr <= head_addr;
                  o_mem_data <= head_data;
               end else if (i_ld_req) begin
                  state      <= LD_BUSY;
                  o_mem_req  <= 1'b1;
                  o_mem_we   <= MEM_OP_LOAD;
                  o_mem_addr <= i_ld_addr;
                  o_mem_data <= '0;
                  // Only loads that bypass waiting stores count as starvation.
                  if (!fifo_empty && starve != STARVE_MAX)
                     starve <= starve + 1'b1;
               end else begin
                  o_mem_req <= 1'b0;
               end
            end
            ST_BUSY, LD_BUSY: begin
               if (i_mem_ack) begin
                  state      <= IDLE;
                  o_mem_req  <= 1'b0;
                  o_mem_we   <= 1'b0;
                  o_mem_addr <= '0;
                  o_mem_data <= '0;
               end
            end
            default: begin
               state     <= IDLE;
               o_mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_store_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_store_ctrl: directed vector table plus multi-cycle sequences   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_wb_store_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_st_valid = 1'b0;
   logic [31:0] i_st_addr = '0;
   logic [31:0] i_st_data = '0;
   logic        o_st_stall;
   logic        i_ld_req = 1'b0;
   logic [31:0] i_ld_addr = '0;
   logic        o_ld_conflict;
   logic        o_ld_done;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_data;
   logic        i_mem_ack = 1'b0;
   logic [2:0]  o_sq_count;
   logic        o_sq_empty;

   int checks = 0;
   int errors = 0;

   wb_store_ctrl #(.DEPTH(4), .STARVE_LIMIT(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_st_valid    (i_st_valid),
      .i_st_addr     (i_st_addr),
      .i_st_data     (i_st_data),
      .o_st_stall    (o_st_stall),
      .i_ld_req      (i_ld_req),
      .i_ld_addr     (i_ld_addr),
      .o_ld_conflict (o_ld_conflict),
      .o_ld_done     (o_ld_done),
      .o_mem_req     (o_mem_req),
      .o_mem_we      (o_mem_we),
      .o_mem_addr    (o_mem_addr),
      .o_mem_data    (o_mem_data),
      .i_mem_ack     (i_mem_ack),
      .o_sq_count    (o_sq_count),
      .o_sq_empty    (o_sq_empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sv;  logic [31:0] sa; logic [31:0] sd;
      logic        lr;  logic [31:0] la; logic        ak;
      logic        req; logic        we; logic [31:0] ma; logic [31:0] md;
      logic        cf;  logic        dn; logic [2:0]  cn; logic stall; logic emp;
   } vec_t;

   vec_t tv [22];

   function automatic vec_t mk(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                               input logic lr, input logic [31:0] la, input logic ak,
                               input logic req, input logic we, input logic [31:0] ma,
                               input logic [31:0] md, input logic cf, input logic dn,
                               input logic [2:0] cn, input logic stall, input logic emp);
      vec_t v;
      v.sv = sv; v.sa = sa; v.sd = sd; v.lr = lr; v.la = la; v.ak = ak;
      v.req = req; v.we = we; v.ma = ma; v.md = md; v.cf = cf; v.dn = dn;
      v.cn = cn; v.stall = stall; v.emp = emp;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Bounded wait for the forced store; counts load grants issued while the queue is non-empty.
   task automatic run_starve(input logic [31:0] exp_addr, input logic [31:0] exp_data,
                             output int grants);
      logic seen;
      seen   = 1'b0;
      grants = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk); #1;
         if (o_mem_req && o_mem_we) begin
            seen = 1'b1;
            chk("starve store addr", o_mem_addr, exp_addr);
            chk("starve store data", o_mem_data, exp_data);
         end else if (o_mem_req && !o_mem_we && o_sq_count != 3'd0) begin
            grants++;
         end
      end
      chk("starve store seen", 32'(seen), 32'd1);
   endtask

   initial begin
      int g;
      // Fields: st_valid, st_addr, st_data, ld_req, ld_addr, ack |
      //         mem_req, we, mem_addr, mem_data, conflict, done, count, stall, empty
      tv[0]  = mk(0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 0, 0, 0, 0, 1);
      tv[1]  = mk(1, 32'h1000, 32'hDEADBEEF, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 1);
      tv[2]  = mk(0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 0, 0, 1, 0, 0);
      tv[3]  = mk(0, 0, 0, 0, 0, 0,                     1, 1, 32'h1000, 32'hDEADBEEF, 0, 0, 1, 0, 0);
      tv[4]  = mk(0, 0, 0, 0, 0, 1,                     1, 1, 32'h1000, 32'hDEADBEEF, 0, 0, 1, 0, 0);
      tv[5]  = mk(0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 0, 0, 0, 0, 1);
      tv[6]  = mk(1, 32'h2004, 32'h11112222, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 1);
      tv[7]  = mk(0, 0, 0, 1, 32'h2006, 0,              0, 0, 0, 0, 1, 0, 1, 0, 0);
      tv[8]  = mk(0, 0, 0, 1, 32'h2006, 0,              1, 1, 32'h2004, 32'h11112222, 1, 0, 1, 0, 0);
      tv[9]  = mk(0, 0, 0, 1, 32'h2006, 1,              1, 1, 32'h2004, 32'h11112222, 1, 0, 1, 0, 0);
      tv[10] = mk(0, 0, 0, 1, 32'h2006, 0,              0, 0, 0, 0, 0, 0, 0, 0, 1);
      tv[11] = mk(0, 0, 0, 1, 32'h2006, 0,              1, 0, 32'h2006, 0, 0, 0, 0, 0, 1);
      tv[12] = mk(0, 0, 0, 1, 32'h2006, 1,              1, 0, 32'h2006, 0, 0, 1, 0, 0, 1);
      tv[13] = mk(0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 0, 0, 0, 0, 1);
      tv[14] = mk(0, 0, 0, 0, 0, 1,                     0, 0, 0, 0, 0, 0, 0, 0, 1);
      tv[15] = mk(0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 0, 0, 0, 0, 1);
      tv[16] = mk(1, 32'h3000, 32'hA5A5A5A5, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 1);
      tv[17] = mk(0, 0, 0, 1, 32'h3004, 0,              0, 0, 0, 0, 0, 0, 1, 0, 0);
      tv[18] = mk(0, 0, 0, 1, 32'h3004, 1,              1, 0, 32'h3004, 0, 0, 1, 1, 0, 0);
      tv[19] = mk(0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 0, 0, 1, 0, 0);
      tv[20] = mk(0, 0, 0, 0, 0, 1,                     1, 1, 32'h3000, 32'hA5A5A5A5, 0, 0, 1, 0, 0);
      tv[21] = mk(0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 0, 0, 0, 0, 1);

      repeat (3) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         i_st_valid = tv[i].sv; i_st_addr = tv[i].sa; i_st_data = tv[i].sd;
         i_ld_req   = tv[i].lr; i_ld_addr = tv[i].la; i_mem_ack = tv[i].ak;
         #1;
         chk($sformatf("v%0d mem_req", i),  32'(o_mem_req),     32'(tv[i].req));
         chk($sformatf("v%0d mem_we", i),   32'(o_mem_we),      32'(tv[i].we));
         chk($sformatf("v%0d mem_addr", i), o_mem_addr,         tv[i].ma);
         chk($sformatf("v%0d mem_data", i), o_mem_data,         tv[i].md);
         chk($sformatf("v%0d conflict", i), 32'(o_ld_conflict), 32'(tv[i].cf));
         chk($sformatf("v%0d ld_done", i),  32'(o_ld_done),     32'(tv[i].dn));
         chk($sformatf("v%0d count", i),    32'(o_sq_count),    32'(tv[i].cn));
         chk($sformatf("v%0d stall", i),    32'(o_st_stall),    32'(tv[i].stall));
         chk($sformatf("v%0d empty", i),    32'(o_sq_empty),    32'(tv[i].emp));
      end

      // Fill to full with the memory holding off its ack.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         i_st_valid = 1'b1; i_st_addr = 32'h100 + 32'(4 * k); i_st_data = 32'(k + 1);
         i_ld_req = 1'b0; i_mem_ack = 1'b0;
      end
      @(negedge clk);
      i_st_addr = 32'h110; i_st_data = 32'd5;
      #1;
      chk("full stall", 32'(o_st_stall), 32'd1);
      chk("full count", 32'(o_sq_count), 32'd4);
      chk("full head addr", o_mem_addr, 32'h100);
      @(negedge clk); #1;
      chk("full held stall", 32'(o_st_stall), 32'd1);
      chk("full held count", 32'(o_sq_count), 32'd4);
      i_mem_ack = 1'b1;
      @(negedge clk);
      i_mem_ack = 1'b0;
      #1;
      chk("full stall drop", 32'(o_st_stall), 32'd0);
      chk("full count after ack", 32'(o_sq_count), 32'd3);
      @(negedge clk);
      i_st_valid = 1'b0;
      #1;
      chk("fifth enqueued", 32'(o_sq_count), 32'd4);
      for (int k = 1; k <= 4; k++) begin
         #1;
         chk($sformatf("drain%0d req", k),  32'(o_mem_req), 32'd1);
         chk($sformatf("drain%0d addr", k), o_mem_addr, 32'h100 + 32'(4 * k));
         chk($sformatf("drain%0d data", k), o_mem_data, 32'(k + 1));
         i_mem_ack = 1'b1;
         @(negedge clk);
         i_mem_ack = 1'b0;
         #1;
         chk($sformatf("drain%0d idle", k),  32'(o_mem_req), 32'd0);
         chk($sformatf("drain%0d count", k), 32'(o_sq_count), 32'(4 - k));
         @(negedge clk);
      end

      // Starvation: load held high with immediate acks, one store waiting.
      i_ld_req = 1'b1; i_ld_addr = 32'h6000; i_mem_ack = 1'b0;
      @(negedge clk);
      i_st_valid = 1'b1; i_st_addr = 32'h5000; i_st_data = 32'h55; i_mem_ack = 1'b1;
      @(negedge clk);
      i_st_valid = 1'b0;
      run_starve(32'h5000, 32'h55, g);
      chk("starve grants round1", 32'(g), 32'd4);
      i_st_valid = 1'b1; i_st_addr = 32'h5100; i_st_data = 32'h66;
      @(negedge clk);
      i_st_valid = 1'b0;
      #1;
      chk("push+pop count", 32'(o_sq_count), 32'd1);
      chk("push+pop idle", 32'(o_mem_req), 32'd0);
      run_starve(32'h5100, 32'h66, g);
      chk("starve grants round2", 32'(g), 32'd4);
      i_ld_req = 1'b0;
      @(negedge clk);
      i_mem_ack = 1'b0;
      #1;
      chk("starve end count", 32'(o_sq_count), 32'd0);
      chk("starve end req", 32'(o_mem_req), 32'd0);

      // Reset in the middle of a store transaction.
      @(negedge clk);
      i_st_valid = 1'b1; i_st_addr = 32'h7000; i_st_data = 32'h77;
      @(negedge clk);
      i_st_valid = 1'b0;
      @(negedge clk); #1;
      chk("pre-reset req", 32'(o_mem_req), 32'd1);
      chk("pre-reset we", 32'(o_mem_we), 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("async reset req", 32'(o_mem_req), 32'd0);
      chk("async reset addr", o_mem_addr, 32'd0);
      chk("async reset count", 32'(o_sq_count), 32'd0);
      chk("async reset empty", 32'(o_sq_empty), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk); #1;
      chk("post-reset idle", 32'(o_mem_req), 32'd0);
      i_st_valid = 1'b1; i_st_addr = 32'h7100; i_st_data = 32'h71;
      @(negedge clk);
      i_st_valid = 1'b0;
      @(negedge clk); #1;
      chk("post-reset store req", 32'(o_mem_req), 32'd1);
      chk("post-reset store addr", o_mem_addr, 32'h7100);
      i_mem_ack = 1'b1;
      @(negedge clk);
      i_mem_ack = 1'b0;
      #1;
      chk("post-reset drained", 32'(o_sq_count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
